// File: rtl/ham_pkg.sv
// Shared Hamming(7,4) definitions used by the serial receive path.
package ham_pkg;

    localparam int HAM74_CW_W   = 7;
    localparam int HAM74_DATA_W = 4;

    typedef logic [HAM74_CW_W-1:0] ham74_cw_t;

endpackage : ham_pkg

// File: rtl/serial_deserializer.sv
// Serial-to-parallel converter: gathers bit_in into WIDTH-bit words with
// selectable bit order and frame restart, then presents each word through a
// one-deep valid/ready holding register with a sticky overrun flag.
module serial_deserializer
    import ham_pkg::*;
#(
    parameter int WIDTH     = HAM74_CW_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     bit_valid,
    input  logic                     bit_in,
    input  logic                     frame_start,
    input  logic                     word_ready,
    input  logic                     clear_overrun,
    output logic [WIDTH-1:0]         word_out,
    output logic                     word_valid,
    output logic                     overrun,
    output logic [$clog2(WIDTH)-1:0] bit_count
);

    localparam int             CW         = $clog2(WIDTH);
    // Position where a freshly received bit enters the shift register.
    localparam int             IN_POS     = MSB_FIRST ? 0 : WIDTH - 1;
    localparam logic [CW-1:0]  LAST_COUNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] word_reg;
    logic             valid_reg;
    logic             overrun_reg;

    // shifted: partial word with bit_in appended; start_word: bit_in alone
    // as the first bit of a brand-new word.
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] start_word;
    logic             completing;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        if (gi == IN_POS) begin : g_entry
            assign shifted[gi]    = bit_in;
            assign start_word[gi] = bit_in;
        end else begin : g_move
            if (MSB_FIRST) begin : g_left
                assign shifted[gi] = shift_reg[gi-1];
            end else begin : g_right
                assign shifted[gi] = shift_reg[gi+1];
            end
            assign start_word[gi] = 1'b0;
        end
    end

    // A frame restart never completes a word, even at the last bit position.
    assign completing = bit_valid && !frame_start && (count_reg == LAST_COUNT);

    // Next state of the shift/count datapath.
    always_comb begin
        shift_next = shift_reg;
        count_next = count_reg;
        if (frame_start) begin
            shift_next = bit_valid ? start_word : '0;
            count_next = bit_valid ? CW'(1) : '0;
        end else if (bit_valid) begin
            shift_next = completing ? '0 : shifted;
            count_next = completing ? '0 : count_reg + CW'(1);
        end
    end

    // Shift register and bit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            count_reg <= '0;
        end else begin
            shift_reg <= shift_next;
            count_reg <= count_next;
        end
    end

    // Output holding register: load on completion if the slot is free or is
    // being emptied this edge, otherwise drop the word and flag overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (completing) begin
                if (!valid_reg || word_ready) begin
                    word_reg  <= shifted;
                    valid_reg <= 1'b1;
                end
            end else if (valid_reg && word_ready) begin
                valid_reg <= 1'b0;
            end

            // A drop in the same cycle as a clear leaves the flag set.
            if (completing && valid_reg && !word_ready) begin
                overrun_reg <= 1'b1;
            end else if (clear_overrun) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign word_out   = word_reg;
    assign word_valid = valid_reg;
    assign overrun    = overrun_reg;
    assign bit_count  = count_reg;

endmodule : serial_deserializer

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench: two deserializers (MSB-first and LSB-first) share one
// stimulus stream; a reference model predicts words, a monitor checks them.
module tb_serial_deserializer;
    import ham_pkg::*;

    localparam int W  = HAM74_CW_W;
    localparam int CW = $clog2(W);

    logic clk = 1'b0;
    logic reset, bit_valid, bit_in, frame_start, word_ready, clear_overrun;
    logic [W-1:0]  word_out_m, word_out_l;
    logic          valid_m, valid_l, ovr_m, ovr_l;
    logic [CW-1:0] cnt_m, cnt_l;

    always #5 clk = ~clk;

    serial_deserializer #(.WIDTH(HAM74_CW_W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
        .frame_start(frame_start), .word_ready(word_ready),
        .clear_overrun(clear_overrun), .word_out(word_out_m),
        .word_valid(valid_m), .overrun(ovr_m), .bit_count(cnt_m)
    );

    serial_deserializer #(.WIDTH(HAM74_CW_W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
        .frame_start(frame_start), .word_ready(word_ready),
        .clear_overrun(clear_overrun), .word_out(word_out_l),
        .word_valid(valid_l), .overrun(ovr_l), .bit_count(cnt_l)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: bits of the current partial word in arrival
    // order, whether a word is held, the overrun flag, and expected words.
    bit        part_q[$];
    bit        held;
    bit        ovr;
    ham74_cw_t exp_m_q[$];
    ham74_cw_t exp_l_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ham74_cw_t assemble(input bit msb);
        ham74_cw_t w = '0;
        for (int i = 0; i < part_q.size(); i++) begin
            if (msb) w[W-1-i] = part_q[i];
            else     w[i]     = part_q[i];
        end
        return w;
    endfunction

    task automatic model_reset();
        part_q.delete();
        exp_m_q.delete();
        exp_l_q.delete();
        held = 1'b0;
        ovr  = 1'b0;
    endtask

    // Effect of one clock edge with the given inputs.
    task automatic model_apply(input bit bv, input bit bi, input bit fs, input bit rdy, input bit clr);
        bit        complete = 1'b0;
        bit        drop     = 1'b0;
        ham74_cw_t wm = '0;
        ham74_cw_t wl = '0;
        if (fs) begin
            part_q.delete();
            if (bv) part_q.push_back(bi);
        end else if (bv) begin
            part_q.push_back(bi);
            if (part_q.size() == W) begin
                complete = 1'b1;
                wm = assemble(1'b1);
                wl = assemble(1'b0);
                part_q.delete();
            end
        end
        if (complete) begin
            if (!held || rdy) begin
                held = 1'b1;
                exp_m_q.push_back(wm);
                exp_l_q.push_back(wl);
            end else begin
                drop = 1'b1;
            end
        end else if (held && rdy) begin
            held = 1'b0;
        end
        if (drop)     ovr = 1'b1;
        else if (clr) ovr = 1'b0;
    endtask

    // Drive one cycle of inputs; the model advances after the edge samples them.
    task automatic step(input bit bv, input bit bi, input bit fs, input bit rdy, input bit clr);
        bit_valid     = bv;
        bit_in        = bi;
        frame_start   = fs;
        word_ready    = rdy;
        clear_overrun = clr;
        @(posedge clk);
        #1;
        model_apply(bv, bi, fs, rdy, clr);
    endtask

    // Send a word MSB-of-w first; word_ready is rdy_body except on the last bit.
    task automatic send_word(input logic [6:0] w, input bit rdy_body, input bit rdy_last);
        logic [6:0] wv;
        wv = w;
        for (int i = W - 1; i >= 0; i--) begin
            step(1'b1, wv[i], 1'b0, (i == 0) ? rdy_last : rdy_body, 1'b0);
        end
    endtask

    // Monitor: compares DUT outputs with the model and pops accepted words.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0) begin
                check("valid_m", valid_m, held);
                check("valid_l", valid_l, held);
                check("overrun_m", ovr_m, ovr);
                check("overrun_l", ovr_l, ovr);
                check("bit_count_m", cnt_m, part_q.size());
                check("bit_count_l", cnt_l, part_q.size());
                if (valid_m === 1'b1 || valid_l === 1'b1) begin
                    if (exp_m_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL word_unexpected: got valid with word %0h, expected no word at %0t",
                                 word_out_m, $time);
                    end else begin
                        check("word_m", word_out_m, exp_m_q[0]);
                        check("word_l", word_out_l, exp_l_q[0]);
                        if (word_ready) begin
                            $display("word accepted: msb %02h lsb %02h", word_out_m, word_out_l);
                            void'(exp_m_q.pop_front());
                            void'(exp_l_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        bit_valid = 1'b0; bit_in = 1'b0; frame_start = 1'b0;
        word_ready = 1'b0; clear_overrun = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_word", word_out_m, 0);
        check("reset_valid", valid_m, 0);
        check("reset_overrun", ovr_m, 0);
        check("reset_count", cnt_m, 0);
        reset = 1'b0;

        // Basic word, both bit orders.
        send_word(7'b1011001, 1'b1, 1'b1);
        check("t1_word_msb", word_out_m, 7'b1011001);
        check("t1_word_lsb", word_out_l, 7'b1001101);
        check("t1_valid", valid_m, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t1_valid_drop", valid_m, 0);

        // Overrun: two words with no acceptance.
        send_word(7'h59, 1'b0, 1'b0);
        send_word(7'h2A, 1'b0, 1'b0);
        check("t3_hold", word_out_m, 7'h59);
        check("t3_overrun", ovr_m, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_lost", valid_m, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t3_clear", ovr_m, 0);

        // Back-to-back: held word consumed on the edge that completes the next.
        send_word(7'h15, 1'b0, 1'b0);
        send_word(7'h6C, 1'b0, 1'b1);
        check("t4_word", word_out_m, 7'h6C);
        check("t4_valid", valid_m, 1);
        check("t4_overrun", ovr_m, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Frame restart discards a partial word.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_count3", cnt_m, 3);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t5_count0", cnt_m, 0);
        send_word(7'b0111000, 1'b1, 1'b1);
        check("t5_word", word_out_m, 7'b0111000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Frame restart with a bit at the last position does not complete.
        for (int i = 0; i < W - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t5b_count1", cnt_m, 1);
        check("t5b_novalid", valid_m, 0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset while a word is held and a partial is in flight.
        send_word(7'h33, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        bit_valid = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check("t6_word_m", word_out_m, 0);
        check("t6_word_l", word_out_l, 0);
        check("t6_valid", valid_m, 0);
        check("t6_count", cnt_m, 0);
        check("t6_overrun", ovr_m, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_word(7'h7F, 1'b1, 1'b1);
        check("t6_word_7f_m", word_out_m, 7'h7F);
        check("t6_word_7f_l", word_out_l, 7'h7F);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 99) < 3,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_serial_deserializer

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
Parametrised serial-to-parallel converter. Collects a bit stream into WIDTH-bit words, with selectable bit order and explicit framing. Presents each completed word on a valid/ready output with a one-word holding register and a sticky overrun flag. It sits between the serial line receiver and the Hamming decoder; the default WIDTH=7 carries one Hamming(7,4) codeword.

Parameters:
WIDTH, 7, word length in bits; legal range 2..64.
MSB_FIRST, 1, 1 = first received bit lands in word bit WIDTH-1; 0 = first bit lands in bit 0.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
bit_valid  input  1  bit_in is sampled on this cycle.
bit_in  input  1  serial data bit.
frame_start  input  1  synchronous; discards any partial word and restarts framing.
word_ready  input  1  downstream accepts word_out this cycle.
clear_overrun  input  1  synchronous clear of overrun.
word_out  output  WIDTH  assembled word, registered.
word_valid  output  1  word_out holds an unconsumed word.
overrun  output  1  sticky; a completed word was dropped.
bit_count  output  $clog2(WIDTH)  bits of the current partial word collected so far (0..WIDTH-1).

Behaviour:
- Reset (async assert, sync release): shift register, bit_count, word_out, word_valid and overrun all 0.
- Bit accept:
  - Every cycle with bit_valid=1 accepts bit_in. There is no input backpressure; the serial side never stalls.
  - MSB_FIRST=1: shift left, new bit enters at bit 0.
  - MSB_FIRST=0: shift right, new bit enters at bit WIDTH-1.
  - bit_count increments per accepted bit.
- Word complete: the bit accepted when bit_count==WIDTH-1 completes the word.
  - bit_count wraps to 0 on that same edge.
  - The completed word (shift contents plus the new bit) is the load candidate.
- Output load, evaluated on the completing edge:
  - If word_valid=0, or word_valid=1 and word_ready=1 in the same cycle: load word_out and set word_valid=1.
  - Otherwise: drop the new word, set overrun=1, leave word_out and word_valid unchanged.
- Latency: word_valid rises on the clock edge that accepts the last bit. The word is visible the cycle after the last bit_valid.
- Handshake:
  - A word transfers when word_valid & word_ready at a rising edge.
  - If no new word loads on that edge, word_valid clears.
  - word_out must stay stable while word_valid=1 and word_ready=0.
  - word_ready while word_valid=0 has no effect.
- frame_start:
  - With bit_valid=0: bit_count becomes 0 and the partial word is discarded.
  - With bit_valid=1: bit_in becomes the first bit of a new word and bit_count becomes 1.
  - It never completes a word, even if bit_count==WIDTH-1, and never affects word_out, word_valid or overrun.
- overrun: set only by a dropped word. clear_overrun clears it. If set and clear occur in the same cycle, set wins.
- Reset mid-word or mid-handshake: partial and held words are discarded. The first bit after reset is bit 1 of a new word.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package ham_pkg:
  - HAM74_CW_W=7, HAM74_DATA_W=4.
  - typedef ham74_cw_t, a logic [6:0] codeword.
  - Top-level instances use HAM74_CW_W for WIDTH.
- No sub-module is required. The shift/count datapath and the output holding register are written as two always_ff blocks in one module.

Test Plan:
- WIDTH=7, MSB_FIRST=1, bits 1,0,1,1,0,0,1 on consecutive cycles, word_ready=1 -> word_out=7'b1011001; word_valid=1 for exactly one cycle, starting the cycle after the 7th bit.
- MSB_FIRST=0, same bits -> word_out=7'b1001101.
- word_ready=0, send 14 bits (two words: 7'h59 then 7'h2A) -> word_out holds 7'h59; overrun=1 after the 14th bit. Then word_ready=1 for one cycle -> word_valid=0; the second word is lost. clear_overrun -> overrun=0.
- Back-to-back: word_valid=1 with word_ready=1 on the same edge as the next word's last bit -> word_out takes the new word, word_valid stays 1, overrun stays 0.
- 3 bits, then frame_start with bit_valid=0, then 7 bits 0,1,1,1,0,0,0 (MSB_FIRST=1) -> word_out=7'b0111000; bit_count 3->0 at frame_start.
- Assert reset after 4 bits and while a word is held -> all outputs 0 immediately. After release, 7 bits 1,1,1,1,1,1,1 -> word_out=7'h7F.
